// File: rtl/xlr8_pcint_pkg.sv
// Shared register-map constants and address decode for the multi-port pin-change controller.
// Optional build macro: XLR8_PCINT_PINFLAG_EN (adds the per-pin PCPFn registers).
package xlr8_pcint_pkg;

  localparam int OFS_PCICR   = 0;
  localparam int OFS_PCIFR   = 1;
  localparam int OFS_PORT    = 2;
  localparam int PORT_STRIDE = 3;
  localparam int MAX_NPORTS  = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PCICR,
    REG_PCIFR,
    REG_PCMSK,
    REG_PCREN,
    REG_PCFEN,
    REG_PCPF
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] port;
  } reg_dec_t;

  // Maps a DM address onto a register kind plus port index; REG_NONE when unmapped.
  function automatic reg_dec_t decode_addr(input logic [7:0] adr,
                                           input logic [7:0] base,
                                           input int         nports,
                                           input bit         pinflag);
    reg_dec_t   d;
    logic [7:0] off;
    d.kind = REG_NONE;
    d.port = '0;
    off    = adr - base;
    if (adr >= base) begin
      if (off == 8'(OFS_PCICR)) d.kind = REG_PCICR;
      if (off == 8'(OFS_PCIFR)) d.kind = REG_PCIFR;
      for (int p = 0; p < MAX_NPORTS; p++) begin
        if (p < nports) begin
          if (off == 8'(OFS_PORT + PORT_STRIDE * p)) begin
            d.kind = REG_PCMSK;
            d.port = 3'(p);
          end
          if (off == 8'(OFS_PORT + PORT_STRIDE * p + 1)) begin
            d.kind = REG_PCREN;
            d.port = 3'(p);
          end
          if (off == 8'(OFS_PORT + PORT_STRIDE * p + 2)) begin
            d.kind = REG_PCFEN;
            d.port = 3'(p);
          end
          if (pinflag && (off == 8'(OFS_PORT + PORT_STRIDE * nports + p))) begin
            d.kind = REG_PCPF;
            d.port = 3'(p);
          end
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/xlr8_pcint_port.sv
// One pin-change port: input synchroniser, edge qualification and mask, optional sticky pin flags.
// Optional build macro: XLR8_PCINT_PINFLAG_EN (adds the PCPF register and its ports).
module xlr8_pcint_port
  import xlr8_pcint_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             prime_done,
  input  logic [WIDTH-1:0] pcmsk,
  input  logic [WIDTH-1:0] pcren,
  input  logic [WIDTH-1:0] pcfen,
`ifdef XLR8_PCINT_PINFLAG_EN
  input  logic             pf_wr,
  input  logic [WIDTH-1:0] pf_wdata,
  input  logic             pf_ack,
  output logic [WIDTH-1:0] pcpf,
`endif
  output logic             port_evt
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] s, rise, fall, hit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    s      = sync_q[SYNC_STAGES-1];
    prev_d = s;
    rise   = s & ~prev_q & pcren;
    fall   = ~s & prev_q & pcfen;
    // Edges are suppressed until the synchroniser has settled after reset.
    hit    = (rise | fall) & pcmsk & {WIDTH{prime_done}};
  end

  assign port_evt = |hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef XLR8_PCINT_PINFLAG_EN
  logic [WIDTH-1:0] pcpf_q, pcpf_d;

  // A new hit always survives a same-cycle clear so software never loses a cause.
  always_comb begin
    pcpf_d = pcpf_q;
    if (pf_ack) begin
      pcpf_d = '0;
    end else if (pf_wr) begin
      pcpf_d = pcpf_q & ~pf_wdata;
    end
    pcpf_d = pcpf_d | hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcpf_q <= '0;
    end else begin
      pcpf_q <= pcpf_d;
    end
  end

  assign pcpf = pcpf_q;
`endif

endmodule

// File: rtl/xlr8_pcint_mc.sv
// Multi-port pin-change interrupt controller top: DM decode, PCICR/PCIFR, priming, read mux, IRQs.
// Optional build macro: XLR8_PCINT_PINFLAG_EN (maps the per-port PCPFn pin-flag registers).
module xlr8_pcint_mc
  import xlr8_pcint_pkg::*;
#(
  parameter int         NPORTS      = 3,
  parameter int         WIDTH       = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                ramadr,
  input  logic                      ramre,
  input  logic                      ramwe,
  input  logic                      dm_sel,
  input  logic [7:0]                dbus_in,
  output logic [7:0]                dbus_out,
  output logic                      out_en,
  input  logic [NPORTS*WIDTH-1:0]   pin_in,
  output logic [NPORTS-1:0]         x_irq,
  input  logic [NPORTS-1:0]         x_irq_ack
);

`ifdef XLR8_PCINT_PINFLAG_EN
  localparam bit PINFLAG_EN = 1'b1;
`else
  localparam bit PINFLAG_EN = 1'b0;
`endif
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  reg_dec_t dec;
  logic     addr_hit, wr_en, rd_en, prime_done;

  logic [NPORTS-1:0]             pcicr_q, pcicr_d;
  logic [NPORTS-1:0]             pcifr_q, pcifr_d;
  logic [NPORTS-1:0][WIDTH-1:0]  pcmsk_q, pcmsk_d;
  logic [NPORTS-1:0][WIDTH-1:0]  pcren_q, pcren_d;
  logic [NPORTS-1:0][WIDTH-1:0]  pcfen_q, pcfen_d;
  logic [2:0]                    prime_q, prime_d;
  logic [NPORTS-1:0]             port_evt;

  assign dec        = decode_addr(ramadr, BASE_ADDR, NPORTS, PINFLAG_EN);
  assign addr_hit   = (dec.kind != REG_NONE);
  assign wr_en      = dm_sel & ramwe & addr_hit;
  assign rd_en      = dm_sel & ramre & addr_hit;
  assign prime_done = (prime_q == PRIME_MAX);

`ifdef XLR8_PCINT_PINFLAG_EN
  logic [NPORTS-1:0]            pf_wr;
  logic [NPORTS-1:0][WIDTH-1:0] pcpf;
`endif

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
`ifdef XLR8_PCINT_PINFLAG_EN
    assign pf_wr[g] = wr_en && (dec.kind == REG_PCPF) && (dec.port == 3'(g));
`endif
    xlr8_pcint_port #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .pin_in     (pin_in[g*WIDTH +: WIDTH]),
      .prime_done (prime_done),
      .pcmsk      (pcmsk_q[g]),
      .pcren      (pcren_q[g]),
      .pcfen      (pcfen_q[g]),
`ifdef XLR8_PCINT_PINFLAG_EN
      .pf_wr      (pf_wr[g]),
      .pf_wdata   (dbus_in[WIDTH-1:0]),
      .pf_ack     (x_irq_ack[g]),
      .pcpf       (pcpf[g]),
`endif
      .port_evt   (port_evt[g])
    );
  end

  always_comb begin
    pcicr_d = pcicr_q;
    pcmsk_d = pcmsk_q;
    pcren_d = pcren_q;
    pcfen_d = pcfen_q;
    pcifr_d = pcifr_q;
    prime_d = prime_done ? prime_q : prime_q + 3'd1;
    if (wr_en && (dec.kind == REG_PCICR)) begin
      pcicr_d = dbus_in[NPORTS-1:0];
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (wr_en && (dec.port == 3'(p))) begin
        if (dec.kind == REG_PCMSK) pcmsk_d[p] = dbus_in[WIDTH-1:0];
        if (dec.kind == REG_PCREN) pcren_d[p] = dbus_in[WIDTH-1:0];
        if (dec.kind == REG_PCFEN) pcfen_d[p] = dbus_in[WIDTH-1:0];
      end
    end
    // Set has priority over W1C and ack so a coincident event is never dropped.
    for (int n = 0; n < NPORTS; n++) begin
      if (port_evt[n]) begin
        pcifr_d[n] = 1'b1;
      end else if ((wr_en && (dec.kind == REG_PCIFR) && dbus_in[n]) || x_irq_ack[n]) begin
        pcifr_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcicr_q <= '0;
      pcifr_q <= '0;
      pcmsk_q <= '0;
      pcren_q <= '0;
      pcfen_q <= '0;
      prime_q <= '0;
    end else begin
      pcicr_q <= pcicr_d;
      pcifr_q <= pcifr_d;
      pcmsk_q <= pcmsk_d;
      pcren_q <= pcren_d;
      pcfen_q <= pcfen_d;
      prime_q <= prime_d;
    end
  end

  always_comb begin
    out_en   = rd_en;
    dbus_out = '0;
    if (rd_en) begin
      case (dec.kind)
        REG_PCICR: dbus_out = 8'(pcicr_q);
        REG_PCIFR: dbus_out = 8'(pcifr_q);
        default: begin
          for (int p = 0; p < NPORTS; p++) begin
            if (dec.port == 3'(p)) begin
              if (dec.kind == REG_PCMSK) dbus_out = 8'(pcmsk_q[p]);
              if (dec.kind == REG_PCREN) dbus_out = 8'(pcren_q[p]);
              if (dec.kind == REG_PCFEN) dbus_out = 8'(pcfen_q[p]);
`ifdef XLR8_PCINT_PINFLAG_EN
              if (dec.kind == REG_PCPF)  dbus_out = 8'(pcpf[p]);
`endif
            end
          end
        end
      endcase
    end
  end

  assign x_irq = pcifr_q & pcicr_q;

endmodule
